// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: NM Wishbone B4 classic masters on one side,
// a single slave on the other, plus the one-hot grant and a debug view of
// the arbiter FSM state.
//
// Handshake: a master owns the slave bus while grant_o has its bit set and
// it keeps m_cyc_i high. A beat transfers on a rising edge where
// s_cyc_o & s_stb_o & s_ack_i are all high. The ack reaches only the owning
// master as m_ack_o[g]. The master must hold adr/dat/sel/we stable until
// that ack.
interface wb_arbiter_if #(
  parameter int NM = 2,
  parameter int AW = 30,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM-1:0]    m_we_i;
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [SW-1:0]    s_sel_o;
  logic             s_we_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i;
  logic [NM-1:0]    grant_o;
  logic             state_dbg;   // 0 = IDLE, 1 = GRANT

  // Arbiter view
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output grant_o, state_dbg
  );

  // Environment view (masters plus the slave)
  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  grant_o, state_dbg
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter. NM masters share one slave bus.
// A master keeps its grant for as long as it holds cyc. After each owner
// there is one idle cycle. Only the grant is registered, and the datapath
// is a plain mux.
// Optional macro WBARB_TIMEOUT_EN adds a no-ack watchdog. On expiry the
// watchdog pulses m_err_o to the owner and drops its grant.
module wb_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic        wb_clk_i,
  input logic        wb_reset_ni,
  wb_arbiter_if.slave bus
);
  localparam int SW = DW / 8;
  localparam int IW = $clog2(NM);

  if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_param_check
    $error("wb_arbiter: NM must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;     // last winner, also the current owner in GRANT
  logic [NM-1:0]   req;
  logic [IW-1:0]   win;
  logic            win_vld;
  logic            own;
  logic [IW-1:0]   sel;
  logic            s_cyc;
  logic            s_stb;
  logic            timeout_hit;

  assign own   = (state_q == GRANT);
  assign sel   = own ? last_q : '0;
  assign s_cyc = own & bus.m_cyc_i[sel];
  assign s_stb = s_cyc & bus.m_stb_i[sel];

`ifdef WBARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] to_cnt_q;
  logic [NM-1:0] blk_q;   // master timed out and has not yet dropped cyc

  assign timeout_hit = s_stb & ~bus.s_ack_i & (to_cnt_q == CW'(TIMEOUT));
  assign req         = bus.m_cyc_i & ~blk_q;

  // Count stalled strobe cycles of the current owner; cleared by ack or release
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_ni) begin
      to_cnt_q <= '0;
    end else if (state_d != GRANT || bus.s_ack_i) begin
      to_cnt_q <= '0;
    end else if (own && s_stb) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Lock out a timed-out master until its cyc has been seen low
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_ni) begin
      blk_q <= '0;
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (timeout_hit && last_q == IW'(k)) begin
          blk_q[k] <= 1'b1;
        end else if (!bus.m_cyc_i[k]) begin
          blk_q[k] <= 1'b0;
        end
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign req         = bus.m_cyc_i;
`endif

  // Round-robin pick: first requester after the last winner, cyclically
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      int j;
      j = int'(last_q) + i;
      if (j >= NM) j = j - NM;
      if (!win_vld && req[IW'(j)]) begin
        win     = IW'(j);
        win_vld = 1'b1;
      end
    end
  end

  // FSM state, grant and last-winner registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // FSM next state: grant on any request, release on cyc drop or timeout
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          grant_d = NM'(1) << win;
          last_d  = win;
        end
      end
      GRANT: begin
        if (!$onehot(grant_q) || !grant_q[last_q] ||
            !bus.m_cyc_i[last_q] || timeout_hit) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Pass-through datapath and per-master ack/err steering
  always_comb begin
    bus.s_adr_o   = bus.m_adr_i[sel*AW +: AW];
    bus.s_dat_o   = bus.m_dat_i[sel*DW +: DW];
    bus.s_sel_o   = bus.m_sel_i[sel*SW +: SW];
    bus.s_we_o    = own & bus.m_we_i[sel];
    bus.s_cyc_o   = s_cyc;
    bus.s_stb_o   = s_stb;
    bus.m_dat_o   = bus.s_dat_i;
    bus.grant_o   = grant_q;
    bus.state_dbg = state_q;
    bus.m_ack_o   = '0;
    bus.m_err_o   = '0;
    for (int k = 0; k < NM; k++) begin
      if (own && sel == IW'(k)) begin
        bus.m_ack_o[k] = bus.s_ack_i & s_cyc;
        bus.m_err_o[k] = timeout_hit;
      end
    end
  end
endmodule
